icache_sa: RTL and testbench

ICACHE_SA -- requirements
Module: icache_sa

---
 rtl/icache_sa_pkg.sv | 22 ++
 rtl/icache_way.sv | 66 ++++++
 rtl/icache_sa.sv | 214 +++++++++++++++++++++
 tb/tb_icache_sa.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_sa_pkg.sv
// ============================================================================
// Module  : icache_sa_pkg
// Brief   : Shared defaults, word width and FSM encoding for the I-cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

package icache_sa_pkg;

    localparam int C_WORD_W        = 32;
    localparam int C_DEF_WAYS      = 2;
    localparam int C_DEF_SET_BITS  = 6;
    localparam int C_DEF_LINE_BITS = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

endpackage : icache_sa_pkg

`default_nettype wire

// File: rtl/icache_way.sv
// ============================================================================
// Module  : icache_way
// Brief   : One cache way: valid bits, tag array, data array with a
//           combinational lookup port and a synchronous write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_way
    import icache_sa_pkg::*;
#(
    parameter int SET_BITS  = C_DEF_SET_BITS,
    parameter int LINE_BITS = C_DEF_LINE_BITS,
    parameter int TAG_W     = C_WORD_W - C_DEF_SET_BITS - C_DEF_LINE_BITS - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clr_all,
    input  logic [SET_BITS-1:0]   rd_set,
    input  logic [LINE_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [C_WORD_W-1:0]   rd_data,
    input  logic                  wr_data_en,
    input  logic [SET_BITS-1:0]   wr_set,
    input  logic [LINE_BITS-1:0]  wr_word,
    input  logic [C_WORD_W-1:0]   wr_data,
    input  logic                  wr_tag_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  wr_valid
);

    localparam int SETS = 1 << SET_BITS;
    localparam int WORDS = 1 << (SET_BITS + LINE_BITS);

    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [C_WORD_W-1:0]   r_data [WORDS];

    // Clearing wins over a same-edge tag write so a flushed refill never survives.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (clr_all) begin
            r_valid <= '0;
        end else if (wr_tag_en) begin
            r_valid[wr_set] <= wr_valid;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_tag_en) begin
            r_tag[wr_set] <= wr_tag;
        end
        if (wr_data_en) begin
            r_data[{wr_set, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_set];
    assign rd_tag   = r_tag[rd_set];
    assign rd_data  = r_data[{rd_set, rd_word}];

endmodule : icache_way

`default_nettype wire

// File: rtl/icache_sa.sv
// ============================================================================
// Module  : icache_sa
// Brief   : Set-associative instruction cache with line refill from MemCtrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int WAYS      = C_DEF_WAYS,
    parameter int SET_BITS  = C_DEF_SET_BITS,
    parameter int LINE_BITS = C_DEF_LINE_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 need_mem,
    output logic [C_WORD_W-1:0]  mem_addr,
    input  logic [C_WORD_W-1:0]  mem_ins,
    input  logic                 mem_ins_ready,
    input  logic                 fetch_able,
    input  logic [C_WORD_W-1:0]  input_pc,
    input  logic                 flush,
    output logic                 hit,
    output logic [C_WORD_W-1:0]  hit_ins
);

    localparam int LW    = 1 << LINE_BITS;
    localparam int TAG_W = C_WORD_W - LINE_BITS - SET_BITS - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [LINE_BITS-1:0] C_LAST_BEAT = LINE_BITS'(LW - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LINE_BITS-1:0]   r_beat;
    logic                   r_flush_pending;
    logic [TAG_W-1:0]       r_line_tag;
    logic [SET_BITS-1:0]    r_line_set;
    logic [WAY_W-1:0]       r_victim;

    logic [LINE_BITS-1:0]   w_word;
    logic [SET_BITS-1:0]    w_set;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_unused_pc;

    logic [WAYS-1:0]        w_way_valid;
    logic [TAG_W-1:0]       w_way_tag  [WAYS];
    logic [C_WORD_W-1:0]    w_way_data [WAYS];
    logic [WAYS-1:0]        w_way_hit;
    logic                   w_any_hit;
    logic [C_WORD_W-1:0]    w_hit_data;
    logic [WAY_W-1:0]       w_rr_cur;
    logic [WAY_W-1:0]       w_victim;

    logic                   w_start;
    logic                   w_beat_wr;
    logic                   w_done;
    logic                   w_clr_all;
    logic                   w_set_pend;

    assign w_word      = input_pc[LINE_BITS+1:2];
    assign w_set       = input_pc[LINE_BITS+SET_BITS+1:LINE_BITS+2];
    assign w_tag       = input_pc[C_WORD_W-1:LINE_BITS+SET_BITS+2];
    assign w_unused_pc = ^input_pc[1:0];

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            icache_way #(
                .SET_BITS  (SET_BITS),
                .LINE_BITS (LINE_BITS),
                .TAG_W     (TAG_W)
            ) u_way (
                .clk_in     (clk_in),
                .rst_in     (rst_in),
                .clr_all    (w_clr_all),
                .rd_set     (w_set),
                .rd_word    (w_word),
                .rd_valid   (w_way_valid[g]),
                .rd_tag     (w_way_tag[g]),
                .rd_data    (w_way_data[g]),
                .wr_data_en (w_beat_wr && (r_victim == WAY_W'(g))),
                .wr_set     (r_line_set),
                .wr_word    (r_beat),
                .wr_data    (mem_ins),
                .wr_tag_en  (w_done && (r_victim == WAY_W'(g))),
                .wr_tag     (r_line_tag),
                .wr_valid   (1'b1)
            );
            assign w_way_hit[g] = w_way_valid[g] && (w_way_tag[g] == w_tag);
        end
    endgenerate

    assign w_any_hit = |w_way_hit;

    always_comb begin
        w_hit_data = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_way_hit[i]) begin
                w_hit_data = w_way_data[i];
            end
        end
    end

    assign hit     = fetch_able && (r_state == ST_IDLE) && !flush && w_any_hit;
    assign hit_ins = w_hit_data;

    // Lowest invalid way first; fall back to the set's round-robin pointer.
    always_comb begin
        w_victim = w_rr_cur;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_way_valid[i]) begin
                w_victim = WAY_W'(i);
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] r_rr [1 << SET_BITS];

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    for (int s = 0; s < (1 << SET_BITS); s++) begin
                        r_rr[s] <= '0;
                    end
                end else if (w_done) begin
                    r_rr[r_line_set] <= (r_rr[r_line_set] == WAY_W'(WAYS - 1)) ?
                                        '0 : r_rr[r_line_set] + 1'b1;
                end
            end

            assign w_rr_cur = r_rr[w_set];
        end else begin : g_no_rr
            assign w_rr_cur = '0;
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat_wr   = 1'b0;
        w_done      = 1'b0;
        w_clr_all   = 1'b0;
        w_set_pend  = 1'b0;
        if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        w_clr_all = 1'b1;
                    end else if (fetch_able && !w_any_hit) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    w_set_pend = flush;
                    if (mem_ins_ready) begin
                        w_beat_wr = 1'b1;
                        if (r_beat == C_LAST_BEAT) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                            w_clr_all   = r_flush_pending || flush;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            need_mem        <= 1'b0;
            mem_addr        <= '0;
            r_beat          <= '0;
            r_flush_pending <= 1'b0;
            r_line_tag      <= '0;
            r_line_set      <= '0;
            r_victim        <= '0;
        end else begin
            if (w_start) begin
                need_mem        <= 1'b1;
                mem_addr        <= {input_pc[C_WORD_W-1:LINE_BITS+2], {LINE_BITS{1'b0}}, 2'b00};
                r_beat          <= '0;
                r_flush_pending <= 1'b0;
                r_line_tag      <= w_tag;
                r_line_set      <= w_set;
                r_victim        <= w_victim;
            end
            if (w_beat_wr) begin
                mem_addr <= mem_addr + 32'd4;
                r_beat   <= r_beat + 1'b1;
            end
            if (w_done) begin
                need_mem        <= 1'b0;
                r_flush_pending <= 1'b0;
            end else if (w_set_pend) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

endmodule : icache_sa

`default_nettype wire

// File: tb/tb_icache_sa.sv
// ============================================================================
// Module  : tb_icache_sa
// Brief   : Directed self-checking bench for icache_sa (default parameters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache_sa;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        need_mem;
    logic [31:0] mem_addr;
    logic [31:0] mem_ins;
    logic        mem_ins_ready;
    logic        fetch_able;
    logic [31:0] input_pc;
    logic        flush;
    logic        hit;
    logic [31:0] hit_ins;

    int n_cmp = 0;
    int n_err = 0;

    icache_sa u_dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .need_mem      (need_mem),
        .mem_addr      (mem_addr),
        .mem_ins       (mem_ins),
        .mem_ins_ready (mem_ins_ready),
        .fetch_able    (fetch_able),
        .input_pc      (input_pc),
        .flush         (flush),
        .hit           (hit),
        .hit_ins       (hit_ins)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic beat(input logic [31:0] a);
        chk("beat_addr", mem_addr, a);
        chk("beat_need", {31'd0, need_mem}, 32'd1);
        mem_ins       = memw(a);
        mem_ins_ready = 1'b1;
        tick();
        mem_ins_ready = 1'b0;
        mem_ins       = 32'hDEAD_BEEF;
    endtask

    task automatic fill(input logic [31:0] pc, input logic [31:0] base);
        fetch_able = 1'b1;
        input_pc   = pc;
        #1;
        chk("fill_miss", {31'd0, hit}, 32'd0);
        tick();
        chk("fill_need", {31'd0, need_mem}, 32'd1);
        chk("fill_hit_refill", {31'd0, hit}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            beat(base + 32'(4 * k));
        end
        chk("fill_done", {31'd0, need_mem}, 32'd0);
        chk("fill_rehit", {31'd0, hit}, 32'd1);
        chk("fill_data", hit_ins, memw(pc));
    endtask

    task automatic probe(input logic [31:0] pc, input logic exp_hit, input string tag);
        fetch_able = 1'b1;
        input_pc   = pc;
        #1;
        chk(tag, {31'd0, hit}, {31'd0, exp_hit});
        if (exp_hit) begin
            chk({tag, "_data"}, hit_ins, memw(pc));
        end
        fetch_able = 1'b0;
    endtask

    initial begin
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        mem_ins       = '0;
        mem_ins_ready = 1'b0;
        fetch_able    = 1'b1;
        input_pc      = 32'h0000_1004;
        flush         = 1'b0;
        #12;
        chk("rst_need", {31'd0, need_mem}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Cold miss with word 1 requested, then spatial hit.
        fill(32'h0000_1004, 32'h0000_1000);
        probe(32'h0000_100C, 1'b1, "spatial");
        tick();
        chk("spatial_no_need", {31'd0, need_mem}, 32'd0);

        // Three lines into set 0 of a 2-way cache: 0x3000 evicts 0x1000.
        fill(32'h0000_2000, 32'h0000_2000);
        fill(32'h0000_3000, 32'h0000_3000);
        probe(32'h0000_2000, 1'b1, "assoc_2000");
        probe(32'h0000_3000, 1'b1, "assoc_3000");
        probe(32'h0000_1000, 1'b0, "assoc_1000_evicted");
        tick();
        chk("assoc_no_refill", {31'd0, need_mem}, 32'd0);

        // Flush after beat 2 must not abort the line but clear it at the end.
        fetch_able = 1'b1;
        input_pc   = 32'h0000_1000;
        tick();
        beat(32'h0000_1000);
        beat(32'h0000_1004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_need_kept", {31'd0, need_mem}, 32'd1);
        beat(32'h0000_1008);
        beat(32'h0000_100C);
        chk("flush_need_done", {31'd0, need_mem}, 32'd0);
        probe(32'h0000_1000, 1'b0, "flush_line_gone");
        probe(32'h0000_2000, 1'b0, "flush_other_gone");
        tick();

        // Fetch dropped and rdy_in low for 3 cycles in the middle of a refill.
        fetch_able = 1'b1;
        input_pc   = 32'h0000_1000;
        tick();
        beat(32'h0000_1000);
        fetch_able    = 1'b0;
        input_pc      = 32'h0000_5550;
        rdy_in        = 1'b0;
        mem_ins_ready = 1'b1;
        flush         = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_addr", mem_addr, 32'h0000_1004);
            chk("stall_need", {31'd0, need_mem}, 32'd1);
        end
        rdy_in        = 1'b1;
        mem_ins_ready = 1'b0;
        flush         = 1'b0;
        beat(32'h0000_1004);
        beat(32'h0000_1008);
        beat(32'h0000_100C);
        chk("stall_done", {31'd0, need_mem}, 32'd0);
        probe(32'h0000_1000, 1'b1, "stall_hit_1000");
        probe(32'h0000_1004, 1'b1, "stall_hit_1004");

        // Flush in IDLE: hit gated same cycle, no refill, line gone afterwards.
        fetch_able = 1'b1;
        input_pc   = 32'h0000_1000;
        flush      = 1'b1;
        #1;
        chk("idle_flush_gate", {31'd0, hit}, 32'd0);
        tick();
        flush = 1'b0;
        chk("idle_flush_no_refill", {31'd0, need_mem}, 32'd0);
        probe(32'h0000_1000, 1'b0, "idle_flush_cleared");
        tick();

        // Asynchronous reset between edges during a refill.
        fetch_able = 1'b1;
        input_pc   = 32'h0000_2000;
        tick();
        beat(32'h0000_2000);
        fetch_able = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_need", {31'd0, need_mem}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        #1;
        rst_in = 1'b0;
        mem_ins_ready = 1'b1;
        tick();
        mem_ins_ready = 1'b0;
        chk("stray_need", {31'd0, need_mem}, 32'd0);
        chk("stray_addr", mem_addr, 32'd0);
        probe(32'h0000_2000, 1'b0, "arst_no_line");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_icache_sa

`default_nettype wire
